// File: rtl/nios_system_ram_pkg.sv
// Shared definitions for the pipelined on-chip RAM: FSM state codes, latency bound and
// a parameter sanity helper.
package nios_system_ram_pkg;

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int unsigned LAT_MAX = 2;

  function automatic bit data_w_ok(int unsigned w);
    return (w != 0) && ((w % 8) == 0);
  endfunction

endpackage

// File: rtl/nios_system_ram_array.sv
// Inferred single-port RAM with per-byte write enables and a registered read port.
module nios_system_ram_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nios_system_onchip_ram_pipelined.sv
// Avalon-MM slave on-chip RAM: byte-lane writes, 1- or 2-cycle read latency with
// readdatavalid, clock-enable stall, and a clear engine that fills the array with CLEAR_VALUE.
module nios_system_onchip_ram_pipelined
  import nios_system_ram_pkg::*;
#(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 1024,
  parameter int unsigned       READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter int unsigned       ADDR_W         = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                clear_req,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                clear_busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > LAT_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [0:0]        state_q, state_d;
  logic              init_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              v1_q, v1_d;
  logic              oor1_q, oor1_d;
  logic              v2_q, v2_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;

  logic              clearing, in_range, wr_acc, rd_acc;
  logic              fin_valid;
  logic [DATA_W-1:0] fin_data;
  logic [BE_W-1:0]   ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always_comb begin
    clearing    = (state_q == ST_CLEAR);
    // init_q keeps the slave stalled for the first cycle out of reset in either start mode.
    waitrequest = init_q | clearing | ~clken;
    clear_busy  = clearing;
    in_range    = (32'(address) < DEPTH);
    wr_acc      = chipselect & write & ~waitrequest;
    rd_acc      = chipselect & read & ~write & ~waitrequest;

    ram_we    = '0;
    ram_re    = rd_acc & in_range;
    ram_addr  = address;
    ram_wdata = writedata;
    if (clearing) begin
      ram_addr  = cnt_q;
      ram_wdata = CLEAR_VALUE;
      ram_we    = clken ? {BE_W{1'b1}} : '0;
    end else if (wr_acc && in_range) begin
      ram_we = byteenable;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clken) begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
    end else begin
      cnt_d = '0;
      if (clear_req) begin
        state_d = ST_CLEAR;
      end
    end
  end

  // Every stage advances only on enabled cycles, so a stall delays results without loss.
  always_comb begin
    v1_d   = v1_q;
    oor1_d = oor1_q;
    v2_d   = v2_q;
    rd2_d  = rd2_q;
    if (clken) begin
      v1_d   = rd_acc;
      oor1_d = rd_acc & ~in_range;
      v2_d   = v1_q;
      rd2_d  = oor1_q ? '0 : ram_rdata;
    end
  end

  always_comb begin
    if (READ_LATENCY == LAT_MAX) begin
      fin_valid = v2_q;
      fin_data  = rd2_q;
    end else begin
      fin_valid = v1_q;
      fin_data  = oor1_q ? '0 : ram_rdata;
    end
    // Presented only on an enabled cycle, which is also the cycle the stage retires.
    readdatavalid = fin_valid & clken;
    readdata      = readdatavalid ? fin_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      init_q  <= 1'b1;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      oor1_q  <= 1'b0;
      v2_q    <= 1'b0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b0;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      oor1_q  <= oor1_d;
      v2_q    <= v2_d;
      rd2_q   <= rd2_d;
    end
  end

  nios_system_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_nios_system_onchip_ram_pipelined.sv
// Bench for the pipelined on-chip RAM: three configurations share one stimulus bus, each
// selected by its own chipselect, reset and clear_req.
module tb_nios_system_onchip_ram_pipelined;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, cs, creq;
  logic         rd, wr, clken;
  logic [9:0]   addr;
  logic [3:0]   be;
  logic [31:0]  wdata;
  logic [31:0]  rdata   [N];
  logic         rdv     [N];
  logic         waitreq [N];
  logic         busy    [N];

  int unsigned lat_of [N] = '{1, 2, 1};
  bit          cor_of [N] = '{1'b1, 1'b1, 1'b0};

  int n_chk = 0;
  int n_err = 0;

  logic        o_wait, o_rdv, o_busy;
  logic [31:0] o_data;

  typedef struct {
    string       name;
    bit          cs;
    bit          rd;
    bit          wr;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    bit          ev;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          due;
  } pend_t;

  nios_system_onchip_ram_pipelined #(
    .DATA_W(32), .DEPTH(1024), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0)
  ) u0 (
    .clk(clk), .reset(rst[0]), .address(addr), .byteenable(be), .chipselect(cs[0]),
    .read(rd), .write(wr), .writedata(wdata), .clken(clken), .clear_req(creq[0]),
    .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(waitreq[0]), .clear_busy(busy[0])
  );

  nios_system_onchip_ram_pipelined #(
    .DATA_W(32), .DEPTH(1024), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1),
    .CLEAR_VALUE(32'hA5A5A5A5)
  ) u1 (
    .clk(clk), .reset(rst[1]), .address(addr), .byteenable(be), .chipselect(cs[1]),
    .read(rd), .write(wr), .writedata(wdata), .clken(clken), .clear_req(creq[1]),
    .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(waitreq[1]), .clear_busy(busy[1])
  );

  nios_system_onchip_ram_pipelined #(
    .DATA_W(32), .DEPTH(1000), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'h0)
  ) u2 (
    .clk(clk), .reset(rst[2]), .address(addr), .byteenable(be), .chipselect(cs[2]),
    .read(rd), .write(wr), .writedata(wdata), .clken(clken), .clear_req(creq[2]),
    .readdata(rdata[2]), .readdatavalid(rdv[2]), .waitrequest(waitreq[2]), .clear_busy(busy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle on instance k, sample its outputs within that cycle, then advance.
  task automatic drive(input int k, input bit c, input bit r, input bit w, input logic [9:0] a,
                       input logic [3:0] b, input logic [31:0] d, input bit en, input bit cr);
    cs = '0; cs[k] = c; creq = '0; creq[k] = cr;
    rd = r; wr = w; addr = a; be = b; wdata = d; clken = en;
    #1;
    o_wait = waitreq[k]; o_rdv = rdv[k]; o_data = rdata[k]; o_busy = busy[k];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k, input bit en);
    drive(k, 1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, en, 1'b0);
  endtask

  task automatic write_word(input int k, input logic [9:0] a, input logic [31:0] d);
    drive(k, 1'b1, 1'b0, 1'b1, a, 4'hF, d, 1'b1, 1'b0);
  endtask

  task automatic read_chk(input int k, input logic [9:0] a, input logic [31:0] exp,
                          input string name);
    drive(k, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= int'(lat_of[k]); i++) idle(k, 1'b1);
    chk({name, " valid"}, o_rdv, 1);
    chk({name, " data"}, o_data, exp);
  endtask

  // Counts stalled cycles until waitrequest drops or the budget runs out.
  task automatic count_wait(input int k, input int budget, input int creq_at, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      cs = '0; creq = '0; rd = 1'b0; wr = 1'b0; clken = 1'b1;
      if (i == creq_at) creq[k] = 1'b1;
      #1;
      if (!waitreq[k]) break;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_phase(input int k, input int ncyc, input logic [31:0] init);
    logic [31:0] mm [1024];
    pend_t       pq [$];
    int          ecnt;
    ecnt = 0;
    for (int i = 0; i < 1024; i++) mm[i] = init;
    for (int c = 0; c < ncyc; c++) begin
      bit          en, sel, r, w, exp_v;
      int          op;
      logic [9:0]  a;
      logic [3:0]  b;
      logic [31:0] d, exp_d;
      en  = (c >= ncyc - 4) || ($urandom_range(0, 5) != 0);
      sel = (c < ncyc - 4) && ($urandom_range(0, 3) != 0);
      op  = $urandom_range(0, 4);
      r   = (op <= 1) || (op == 4);
      w   = (op >= 2);
      a   = ($urandom_range(0, 9) == 0) ? 10'(1024 - $urandom_range(1, 8))
                                          : 10'($urandom_range(0, 15));
      b   = 4'($urandom);
      d   = $urandom;
      exp_v = en && (pq.size() > 0) && (pq[0].due == ecnt);
      exp_d = exp_v ? pq[0].d : 32'h0;
      drive(k, sel, r, w, a, b, d, en, 1'b0);
      chk("rand waitrequest", o_wait, !en);
      chk("rand readdatavalid", o_rdv, exp_v);
      if (exp_v) begin
        chk("rand readdata", o_data, exp_d);
        void'(pq.pop_front());
      end
      if (sel && en) begin
        if (w) begin
          for (int l = 0; l < 4; l++) if (b[l]) mm[a][l*8 +: 8] = d[l*8 +: 8];
        end else if (r) begin
          pq.push_back('{mm[a], ecnt + int'(lat_of[k])});
        end
      end
      if (en) ecnt++;
    end
    chk("rand reads outstanding", pq.size(), 0);
  endtask

  function automatic vec_t mk(string n, bit c, bit r, bit w, logic [9:0] a, logic [3:0] b,
                              logic [31:0] d, bit ev, logic [31:0] ed);
    mk.name = n; mk.cs = c; mk.rd = r; mk.wr = w; mk.a = a; mk.be = b; mk.d = d;
    mk.ev = ev; mk.ed = ed;
  endfunction

  initial begin
    vec_t        vecs [$];
    int          hi [N] = '{default: 0};
    int          bz [N] = '{default: 0};
    int          n;
    logic [31:0] t3 [4];

    vecs.push_back(mk("rd0 after clear",    1, 1, 0, 10'd0,    4'h0, 32'h0,        1, 32'h0));
    vecs.push_back(mk("rd511 after clear",  1, 1, 0, 10'd511,  4'h0, 32'h0,        1, 32'h0));
    vecs.push_back(mk("rd1023 after clear", 1, 1, 0, 10'd1023, 4'h0, 32'h0,        1, 32'h0));
    vecs.push_back(mk("wr5 full",           1, 0, 1, 10'd5,    4'hF, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk("wr5 lanes 0,2",      1, 0, 1, 10'd5,    4'h5, 32'h11223344, 0, 32'h0));
    vecs.push_back(mk("rd5 merged",         1, 1, 0, 10'd5,    4'h0, 32'h0,        1, 32'hDE22BE44));
    vecs.push_back(mk("wr7 lane 3",         1, 0, 1, 10'd7,    4'h8, 32'hAABBCCDD, 0, 32'h0));
    vecs.push_back(mk("rd7 lane 3",         1, 1, 0, 10'd7,    4'h0, 32'h0,        1, 32'hAA000000));
    vecs.push_back(mk("wr7 no lanes",       1, 0, 1, 10'd7,    4'h0, 32'hFFFFFFFF, 0, 32'h0));
    vecs.push_back(mk("rd7 unchanged",      1, 1, 0, 10'd7,    4'h0, 32'h0,        1, 32'hAA000000));
    vecs.push_back(mk("wr5 unselected",     0, 0, 1, 10'd5,    4'hF, 32'h0,        0, 32'h0));
    vecs.push_back(mk("rd5 still merged",   1, 1, 0, 10'd5,    4'h0, 32'h0,        1, 32'hDE22BE44));
    vecs.push_back(mk("rd+wr9 write wins",  1, 1, 1, 10'd9,    4'hF, 32'hCAFEF00D, 0, 32'h0));
    vecs.push_back(mk("rd9",                1, 1, 0, 10'd9,    4'h0, 32'h0,        1, 32'hCAFEF00D));
    vecs.push_back(mk("rd9 unselected",     0, 1, 0, 10'd9,    4'h0, 32'h0,        0, 32'h0));
    vecs.push_back(mk("wr1023",             1, 0, 1, 10'd1023, 4'hF, 32'h12345678, 0, 32'h0));
    vecs.push_back(mk("rd1023",             1, 1, 0, 10'd1023, 4'h0, 32'h0,        1, 32'h12345678));

    rst = '1; cs = '0; creq = '0; rd = 1'b0; wr = 1'b0; clken = 1'b1;
    addr = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("reset waitrequest", waitreq[k], 1);
      chk("reset readdatavalid", rdv[k], 0);
      chk("reset readdata", rdata[k], 0);
      chk("reset clear_busy", busy[k], cor_of[k]);
    end

    // Post-reset stall: 1024 cycles with the clear engine, one cycle without.
    rst = '0;
    for (int c = 0; c < 1100; c++) begin
      #1;
      for (int k = 0; k < N; k++) begin
        if (waitreq[k]) hi[k]++;
        if (busy[k]) bz[k]++;
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < N; k++) begin
      chk("post-reset waitrequest cycles", hi[k], cor_of[k] ? 1024 : 1);
      chk("post-reset clear_busy cycles", bz[k], cor_of[k] ? 1024 : 0);
    end

    foreach (vecs[i]) begin
      drive(0, vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].d, 1'b1, 1'b0);
      chk({vecs[i].name, " waitrequest"}, o_wait, 0);
      idle(0, 1'b1);
      chk({vecs[i].name, " valid"}, o_rdv, vecs[i].ev);
      if (vecs[i].ev) chk({vecs[i].name, " data"}, o_data, vecs[i].ed);
    end

    // Latency 2: four back-to-back reads return in order starting two cycles later.
    for (int i = 0; i < 4; i++) begin
      t3[i] = 32'hC0DE0000 | 32'(i * 32'h111);
      write_word(1, 10'(i), t3[i]);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, i < 4, i < 4, 1'b0, 10'(i), 4'h0, 32'h0, 1'b1, 1'b0);
      chk("lat2 burst valid", o_rdv, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk("lat2 burst data", o_data, t3[i-2]);
    end

    // Two reads in flight, then three stalled cycles.
    drive(1, 1'b1, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      chk("stall waitrequest", o_wait, 1);
      chk("stall valid held off", o_rdv, 0);
    end
    idle(1, 1'b1);
    chk("stall first valid", o_rdv, 1);
    chk("stall first data", o_data, t3[2]);
    idle(1, 1'b1);
    chk("stall second valid", o_rdv, 1);
    chk("stall second data", o_data, t3[3]);
    idle(1, 1'b1);
    chk("stall no third valid", o_rdv, 0);

    // DEPTH=1000: out-of-range writes drop, reads return zero with a valid.
    write_word(2, 10'd0, 32'h01010101);
    write_word(2, 10'd999, 32'h99999999);
    write_word(2, 10'd1000, 32'hFFFFFFFF);
    read_chk(2, 10'd0, 32'h01010101, "oor keeps addr0");
    read_chk(2, 10'd999, 32'h99999999, "oor keeps addr999");
    read_chk(2, 10'd1000, 32'h0, "oor read");

    // clear_req alongside an accepted read; a second request mid-clear is ignored.
    drive(0, 1'b1, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(0, 1'b1);
    chk("clear_req read valid", o_rdv, 1);
    chk("clear_req read pre-clear data", o_data, 32'hDE22BE44);
    chk("clear_req busy", o_busy, 1);
    count_wait(0, 1100, 500, n);
    chk("clear_req duration", n + 1, 1024);
    read_chk(0, 10'd5, 32'h0, "cleared addr5");
    rand_phase(0, 2000, 32'h0);

    // Reset with a read in flight: no valid emitted, clear restarts.
    drive(1, 1'b1, 1'b1, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 1'b0);
    rst[1] = 1'b1;
    idle(1, 1'b1);
    rst[1] = 1'b0;
    idle(1, 1'b1);
    chk("flush valid", o_rdv, 0);
    chk("flush waitrequest", o_wait, 1);
    count_wait(1, 1100, -1, n);
    chk("flush clear duration", n + 1, 1024);

    // clear_req, then reset 300 words in: the sequence starts over from word 0.
    drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 1'b1);
    chk("clear_req ready", o_wait, 0);
    for (int i = 0; i < 300; i++) idle(1, 1'b1);
    chk("mid-clear busy", o_busy, 1);
    rst[1] = 1'b1;
    idle(1, 1'b1);
    rst[1] = 1'b0;
    count_wait(1, 1100, -1, n);
    chk("restarted clear duration", n, 1024);
    for (int i = 0; i < 1026; i++) begin
      drive(1, i < 1024, i < 1024, 1'b0, 10'(i), 4'h0, 32'h0, 1'b1, 1'b0);
      if (i >= 2) begin
        chk("fill valid", o_rdv, 1);
        chk("fill data", o_data, 32'hA5A5A5A5);
      end
    end
    rand_phase(1, 2000, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
